// File: rtl/minilogix_pkg.sv
// Shared definitions for the minilogix configuration path: loader FSM state
// encoding and the configuration-length helper.
package minilogix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_TAIL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int STATE_W  = 3;
  localparam int DEF_NIN  = 3;
  localparam int DEF_NOUT = 3;

  // Each output holds a true-select and a complement-select bit per input.
  function automatic int cfg_bits(input int nin, input int nout);
    return nout * 2 * nin;
  endfunction

endpackage

// File: rtl/minilogix_cfg_tick.sv
// Phase timer for the load clock: counts DIV enabled cycles and flags the
// last one so the loader FSM can change phase.
module minilogix_cfg_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase_end
);

  localparam int              PW   = $clog2(DIV + 1);
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  assign phase_end = en && (cnt == LAST);

endmodule

// File: rtl/minilogix_cfg_loader.sv
// Serial configuration loader for minilogix1: shifts one CFG_BITS word out
// MSB first under a generated load clock with DIV-cycle half periods.
module minilogix_cfg_loader
  import minilogix_pkg::*;
#(
  parameter int CFG_BITS = cfg_bits(DEF_NIN, DEF_NOUT),
  parameter int DIV      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CFG_BITS-1:0] i_cfg_data,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic                i_abort,
  output logic                o_load_en,
  output logic                o_load_dat,
  output logic                o_load_clk,
  output logic                o_busy,
  output logic                o_done,
  output logic [2:0]          dbg_state
);

  localparam int            BW       = $clog2(CFG_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);

  state_e              state;
  logic [CFG_BITS-1:0] shreg;
  logic [CFG_BITS-1:0] sh_next;
  logic [BW-1:0]       bit_cnt;
  logic                phase_end;
  logic                tick_en;
  logic                go_idle;

  // Handshake: a word is taken on an edge where i_cfg_valid && o_cfg_ready
  // && !i_abort; o_cfg_ready is high only in IDLE, so nothing is ever queued.

  always_comb begin
    tick_en = 1'b0;
    go_idle = 1'b0;
    sh_next = shreg << 1;
    case (state)
      ST_IDLE: ;
      ST_LOW, ST_HIGH, ST_TAIL: begin
        tick_en = 1'b1;
        go_idle = i_abort;
      end
      ST_DONE: go_idle = 1'b1;
      default: go_idle = 1'b1;
    endcase
  end

  minilogix_cfg_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == ST_IDLE),
    .en        (tick_en),
    .phase_end (phase_end)
  );

  // Outputs are registered alongside the state, so o_load_* never sees an
  // input combinationally; reset and abort share the same return-to-IDLE path.
  always_ff @(posedge clk) begin
    if (rst || go_idle) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      o_cfg_ready <= 1'b1;
      o_load_en   <= 1'b0;
      o_load_clk  <= 1'b0;
      o_load_dat  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_cfg_valid && !i_abort) begin
            state       <= ST_LOW;
            shreg       <= i_cfg_data;
            bit_cnt     <= '0;
            o_cfg_ready <= 1'b0;
            o_load_en   <= 1'b1;
            o_load_clk  <= 1'b0;
            o_load_dat  <= i_cfg_data[CFG_BITS-1];
            o_busy      <= 1'b1;
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            state      <= ST_HIGH;
            o_load_clk <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            // Data only moves here, half a load-clock period after the rise.
            bit_cnt    <= bit_cnt + BW'(1);
            shreg      <= sh_next;
            o_load_clk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state      <= ST_TAIL;
              o_load_dat <= 1'b0;
            end else begin
              state      <= ST_LOW;
              o_load_dat <= sh_next[CFG_BITS-1];
            end
          end
        end
        ST_TAIL: begin
          if (phase_end) begin
            state     <= ST_DONE;
            o_load_en <= 1'b0;
            o_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_minilogix_cfg_loader.sv
// Bench for minilogix_cfg_loader: a DIV=1 and a DIV=2 instance share the clock;
// expected load-data bits are queued at acceptance and popped on each load-clock rise.
module tb_minilogix_cfg_loader;
  import minilogix_pkg::*;

  localparam int N = 18;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic [1:0]   rst;
  logic [1:0]   valid;
  logic [1:0]   abort;
  logic [N-1:0] data [2];
  wire  [1:0]   ready, ld_en, ld_dat, ld_clk, busy, done;
  wire  [2:0]   dbg0, dbg1;

  minilogix_cfg_loader #(.CFG_BITS(N), .DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst[0]), .i_cfg_data(data[0]), .i_cfg_valid(valid[0]),
    .o_cfg_ready(ready[0]), .i_abort(abort[0]), .o_load_en(ld_en[0]),
    .o_load_dat(ld_dat[0]), .o_load_clk(ld_clk[0]), .o_busy(busy[0]),
    .o_done(done[0]), .dbg_state(dbg0)
  );

  minilogix_cfg_loader #(.CFG_BITS(N), .DIV(2)) u_dut_div2 (
    .clk(clk), .rst(rst[1]), .i_cfg_data(data[1]), .i_cfg_valid(valid[1]),
    .o_cfg_ready(ready[1]), .i_abort(abort[1]), .o_load_en(ld_en[1]),
    .o_load_dat(ld_dat[1]), .o_load_clk(ld_clk[1]), .o_busy(busy[1]),
    .o_done(done[1]), .dbg_state(dbg1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  int rise_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int hi_len   [2] = '{0, 0};
  int lo_len   [2] = '{0, 0};
  logic prev_clk [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic [2:0] dbg_of(input int k);
    return (k == 0) ? dbg0 : dbg1;
  endfunction

  task automatic pop_check(input int k);
    logic [0:0] e;
    if (k == 0) begin
      if (exp_q0.size() == 0) check("dat0_extra_edge", 1, 0);
      else begin e = exp_q0.pop_front(); check("dat0_bit", ld_dat[0], e); end
    end else begin
      if (exp_q1.size() == 0) check("dat1_extra_edge", 1, 0);
      else begin e = exp_q1.pop_front(); check("dat1_bit", ld_dat[1], e); end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Load-clock monitor: data on each rise, phase widths, done bookkeeping.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ld_clk[k]) begin
        if (!prev_clk[k]) begin
          rise_cnt[k]++;
          check("low_width", lo_len[k], div_of(k));
          pop_check(k);
          hi_len[k] = 0;
        end
        hi_len[k]++;
      end else begin
        if (prev_clk[k]) begin
          check("high_width", hi_len[k], div_of(k));
          lo_len[k] = 0;
        end
        if (ld_en[k]) lo_len[k]++;
        else lo_len[k] = 0;
      end
      if (done[k]) begin
        done_cnt[k]++;
        check("queue_drained", (k == 0) ? exp_q0.size() : exp_q1.size(), 0);
      end
      prev_clk[k] = ld_clk[k];
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_ready"}, ready[k], 1);
    check({tag, "_en"},    ld_en[k], 0);
    check({tag, "_clk"},   ld_clk[k], 0);
    check({tag, "_dat"},   ld_dat[k], 0);
    check({tag, "_busy"},  busy[k], 0);
    check({tag, "_done"},  done[k], 0);
    check({tag, "_state"}, dbg_of(k), 0);
  endtask

  task automatic push_word(input int k, input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) begin
      if (k == 0) exp_q0.push_back(w[i]);
      else exp_q1.push_back(w[i]);
    end
  endtask

  // Drives a word from IDLE; acc is the cycle in which the word is sampled.
  task automatic start_load(input int k, input logic [N-1:0] w, output int acc);
    check("ready_before_load", ready[k], 1);
    data[k] = w;
    valid[k] = 1'b1;
    rise_cnt[k] = 0;
    push_word(k, w);
    acc = cyc;
    tick();
    valid[k] = 1'b0;
    check("accept_busy", busy[k], 1);
    check("accept_state", dbg_of(k), 1);
    check("accept_ready", ready[k], 0);
  endtask

  task automatic wait_done(input int k, input int acc, output int dcyc);
    int t = 0;
    dcyc = -1;
    while (!done[k] && t < 400) begin
      tick();
      t++;
    end
    if (!done[k]) check("done_timeout", 0, 1);
    else begin
      dcyc = cyc;
      check("done_latency", cyc - acc, 2 * div_of(k) * N + div_of(k) + 1);
      check("rise_count", rise_cnt[k], N);
      check("done_state", dbg_of(k), 4);
      check("done_load_en", ld_en[k], 0);
      tick();
      check("done_one_cycle", done[k], 0);
      check("ready_after_done", ready[k], 1);
      check("busy_after_done", busy[k], 0);
    end
  endtask

  task automatic wait_rise(input int k, input int n, input logic [2:0] st);
    int t = 0;
    while (!(rise_cnt[k] == n && dbg_of(k) == st) && t < 200) begin
      tick();
      t++;
    end
    check("reach_target_phase", (rise_cnt[k] == n && dbg_of(k) == st) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int acc, dcyc, dc, w;
    rst = 2'b11; valid = 2'b00; abort = 2'b00;
    data[0] = '0; data[1] = '0;
    tick(3);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    rst = 2'b00;
    tick();

    // Valid together with abort in IDLE must not start a load.
    data[0] = 18'h2AAAA; valid[0] = 1'b1; abort[0] = 1'b1;
    tick();
    check_idle(0, "valid_abort");
    tick();
    check("valid_abort_busy", busy[0], 0);
    valid[0] = 1'b0; abort[0] = 1'b0;
    tick();

    // Reference word on DIV=1.
    start_load(0, 18'h01B1B, acc);
    wait_done(0, acc, dcyc);
    tick(2);

    // All-ones word on DIV=2; a stray valid mid-load must be dropped.
    start_load(1, 18'h3FFFF, acc);
    tick(10);
    check("busy_ready_low", ready[1], 0);
    data[1] = 18'h15555; valid[1] = 1'b1;
    tick(3);
    valid[1] = 1'b0;
    wait_done(1, acc, dcyc);
    tick(3);
    check("stray_valid_dropped", busy[1], 0);

    // Back-to-back with valid held high across both loads.
    data[0] = 18'h2A5C3; valid[0] = 1'b1; rise_cnt[0] = 0;
    push_word(0, 18'h2A5C3);
    acc = cyc;
    tick();
    check("b2b_first_busy", busy[0], 1);
    data[0] = 18'h1C3A5;
    wait_done(0, acc, dcyc);
    check("b2b_gap_en", ld_en[0], 0);
    rise_cnt[0] = 0;
    push_word(0, 18'h1C3A5);
    acc = cyc;
    tick();
    valid[0] = 1'b0;
    check("b2b_second_busy", busy[0], 1);
    check("b2b_second_en", ld_en[0], 1);
    wait_done(0, acc, dcyc);
    tick(2);

    // Abort during the fifth HIGH phase.
    start_load(0, 18'h3C0F0, acc);
    wait_rise(0, 5, 3'd2);
    dc = done_cnt[0];
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check_idle(0, "abort");
    exp_q0.delete();
    tick(3 * N);
    check("abort_no_done", done_cnt[0], dc);
    w = $urandom_range(0, (1 << N) - 1);
    start_load(0, w[N-1:0], acc);
    wait_done(0, acc, dcyc);
    tick(2);

    // Reset during LOW of bit 10, with valid and abort also high.
    start_load(0, 18'h0F0F3, acc);
    wait_rise(0, 9, 3'd1);
    dc = done_cnt[0];
    rst[0] = 1'b1; valid[0] = 1'b1; abort[0] = 1'b1;
    tick();
    check_idle(0, "reset_mid");
    rst[0] = 1'b0; valid[0] = 1'b0; abort[0] = 1'b0;
    exp_q0.delete();
    tick(3 * N);
    check("reset_no_done", done_cnt[0], dc);
    check("reset_stays_idle", busy[0], 0);

    // Random words on both instances.
    for (int r = 0; r < 2; r++) begin
      w = $urandom_range(0, (1 << N) - 1);
      start_load(1, w[N-1:0], acc);
      wait_done(1, acc, dcyc);
      w = $urandom_range(0, (1 << N) - 1);
      start_load(0, w[N-1:0], acc);
      wait_done(0, acc, dcyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/minilogix_cfg_loader.md
MINILOGIX_CFG_LOADER -- requirements
Module: minilogix_cfg_loader

Interface
REQ-001 Parameter CFG_BITS, default 18: length of the configuration bitstream shifted into one minilogix1 instance.
REQ-002 Parameter DIV, default 2: system-clock cycles per half-period of the generated load clock; legal range is DIV >= 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_cfg_data, input, CFG_BITS bits: configuration word, MSB shifted first.
REQ-006 Port i_cfg_valid, input, 1 bit: i_cfg_data is valid.
REQ-007 Port o_cfg_ready, output, 1 bit: the loader will accept a word this cycle.
REQ-008 Port i_abort, input, 1 bit: cancels any load in progress.
REQ-009 Port o_load_en, output, 1 bit: drives i_load_en of minilogix1.
REQ-010 Port o_load_dat, output, 1 bit: drives i_load_dat of minilogix1.
REQ-011 Port o_load_clk, output, 1 bit: drives i_load_clk of minilogix1.
REQ-012 Port o_busy, output, 1 bit: a load is in progress (any state except IDLE).
REQ-013 Port o_done, output, 1 bit: one-cycle pulse when a load completes normally.
REQ-014 Port dbg_state, output, 3 bits: current FSM state encoding.

Function
REQ-015 The FSM states shall be IDLE=0, LOW=1, HIGH=2, TAIL=3, DONE=4; encodings 5-7 are unreachable and shall map to IDLE on the next edge.
REQ-016 In IDLE: o_cfg_ready=1, o_load_en=0, o_load_clk=0, o_load_dat=0, o_busy=0.
REQ-017 Acceptance rule: i_cfg_valid && o_cfg_ready && !i_abort at an edge latches i_cfg_data into the shift register, clears the bit counter, and enters LOW.
REQ-018 o_cfg_ready shall be 0 in every state except IDLE; valid asserted outside IDLE is ignored and never queued.
REQ-019 LOW lasts DIV cycles with o_load_en=1, o_load_clk=0, and o_load_dat = the current shift-register MSB.
REQ-020 HIGH lasts DIV cycles with o_load_en=1, o_load_clk=1, and o_load_dat held unchanged.
REQ-021 o_load_dat shall change only on the HIGH->LOW transition, so data is stable for DIV cycles on both sides of every rising load-clock edge.
REQ-022 On leaving HIGH the bit counter increments and the shift register shifts left; if the counter reaches CFG_BITS the next state is TAIL, otherwise LOW.
REQ-023 TAIL lasts DIV cycles with o_load_en=1, o_load_clk=0, and o_load_dat=0.
REQ-024 DONE lasts 1 cycle with o_load_en=0 and o_done=1, then returns to IDLE.
REQ-025 Exactly CFG_BITS rising edges of o_load_clk shall occur per load.
REQ-026 Latency: if acceptance occurs at cycle 0, o_done=1 in cycle 2*DIV*CFG_BITS+DIV+1 and o_cfg_ready=1 in the following cycle.
REQ-027 Abort: i_abort=1 in any non-IDLE state forces IDLE at the next edge; o_done shall not pulse, and o_load_en/o_load_clk shall be 0 from that cycle onward.
REQ-028 Abort concurrent with i_cfg_valid in IDLE blocks acceptance.
REQ-029 The phase counter shall be ceil(log2(DIV+1)) bits wide and the bit counter ceil(log2(CFG_BITS+1)) bits wide, with no wrap-around within a load.
REQ-030 DIV=1 shall be supported, giving load-clock edges on alternate system cycles.

Reset
REQ-031 While rst=1 at an edge: state=IDLE, shift register=0, both counters=0, and all outputs take their IDLE values with o_done=0.
REQ-032 rst mid-load shall behave as an abort (no o_done pulse) and takes priority over i_abort and i_cfg_valid.
REQ-033 All outputs shall be registered, with no combinational path from inputs to o_load_*.

Structure
REQ-034 A shared package minilogix_pkg shall hold the state encoding constants and a function cfg_bits(NIN, NOUT) used to derive CFG_BITS.
REQ-035 One sub-module, minilogix_cfg_tick, shall implement the DIV phase counter and produce a phase-end strobe; the FSM and shift register stay in the top module.

Verification
REQ-036 Load with CFG_BITS=18, DIV=1, word 18'h01B1B: the bench shall observe 18 rising edges on o_load_clk, the sampled o_load_dat sequence 000001101100011011, o_done at cycle 38, and o_cfg_ready at cycle 39; when connected to minilogix1, the 3-bit input sweep then yields the inverted-input outputs.
REQ-037 DIV=2, word 18'h3FFFF: the bench shall observe o_load_clk high and low for 2 cycles each, o_done at cycle 75, and o_load_dat=1 at every rising edge.
REQ-038 Back-to-back loads: the bench shall hold i_cfg_valid continuously with two words and observe the second acceptance exactly 1 cycle after o_done, with no glitch on o_load_en between the loads beyond the single DONE cycle.
REQ-039 Abort: the bench shall raise i_abort during the 5th HIGH phase and observe IDLE next cycle, o_load_en=0, no o_done, and a fresh load accepted afterwards completing normally.
REQ-040 Reset mid-load: the bench shall assert rst during LOW of bit 10 and observe all outputs at IDLE values next cycle, dbg_state=0, and no o_done.
REQ-041 Valid+abort in IDLE simultaneously: the bench shall observe no acceptance, with o_busy remaining 0.
